seq_divider: RTL and testbench

Sequential restoring divider, the inverse of the pipelined Vedic multiplier path. It splits a DIVIDEND_W-bit product back into a quotient and remainder by a DIVISOR_W-bit operand. The datapath is iterative, one quotient bit per cycle, with valid/ready handshakes on both sides. It sits beside the multiplier in the matrix datapath for normalisation and checking (a×b ÷ b).

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 31 +++
 rtl/seq_divider.sv | 146 ++++++++++++++
 tb/tb_seq_divider.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

    // Controller states: accept operands, iterate, hold result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Default operand widths.
    localparam int DIV_DIVIDEND_W = 8;
    localparam int DIV_DIVISOR_W  = 4;

    // Iteration counter width for the default dividend width.
    localparam int DIV_CNT_W = $clog2(DIV_DIVIDEND_W);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module div_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W:0]   rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W:0]   rem_o,
    output logic                 q_o
);

    logic [DIVISOR_W:0] trial_s;
    logic [DIVISOR_W:0] dvs_ext_s;

    // Trial subtraction; restore (keep the shifted value) when the divisor does not fit.
    always_comb begin
        trial_s   = {rem_i[DIVISOR_W-1:0], bit_i};
        dvs_ext_s = {1'b0, divisor_i};
        rem_o     = trial_s;
        q_o       = 1'b0;
        if (trial_s >= dvs_ext_s) begin
            rem_o = trial_s - dvs_ext_s;
            q_o   = 1'b1;
        end else begin
            rem_o = trial_s;
            q_o   = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready on
// both sides. Optional macro DIV_ZERO_CHECK_EN short-circuits a zero divisor
// straight to DONE and raises div_by_zero; without it a zero divisor runs
// the normal iterations and div_by_zero stays 0.
module seq_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIV_DIVIDEND_W,
    parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = (DIVIDEND_W > 2) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    // Holds the unconsumed dividend bits; quotient bits shift in from the LSB.
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rmd_q, rmd_d;
    logic                  dbz_q, dbz_d;

    logic [DIVISOR_W:0]    step_rem_s;
    logic                  step_q_s;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[DIVIDEND_W-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem_s),
        .q_o       (step_q_s)
    );

    // Next-state and datapath control for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef DIV_ZERO_CHECK_EN
                    if (divisor == {DIVISOR_W{1'b0}}) begin
                        state_d = DONE;
                        quo_d   = {DIVIDEND_W{1'b1}};
                        rmd_d   = dividend[DIVISOR_W-1:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_LAST;
                        rem_d   = {(DIVISOR_W+1){1'b0}};
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                    end
`else
                    state_d = BUSY;
                    cnt_d   = CNT_LAST;
                    rem_d   = {(DIVISOR_W+1){1'b0}};
                    dvd_d   = dividend;
                    dvs_d   = divisor;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                rem_d = step_rem_s;
                dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q_s};
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = DONE;
                    quo_d   = {dvd_q[DIVIDEND_W-2:0], step_q_s};
                    rmd_d   = step_rem_s[DIVISOR_W-1:0];
                    dbz_d   = 1'b0;
                end else begin
                    state_d = BUSY;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, iteration datapath and result registers; reset aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            rem_q   <= {(DIVISOR_W+1){1'b0}};
            dvd_q   <= {DIVIDEND_W{1'b0}};
            dvs_q   <= {DIVISOR_W{1'b0}};
            quo_q   <= {DIVIDEND_W{1'b0}};
            rmd_q   <= {DIVISOR_W{1'b0}};
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    // Handshake flags decode the state register; results come straight from registers.
    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);
        quotient    = quo_q;
        remainder   = rmd_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized bench for seq_divider (default 8/4 widths).
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

`ifdef DIV_ZERO_CHECK_EN
    localparam int   ZLAT = 0;
    localparam logic ZDBZ = 1'b1;
`else
    localparam int   ZLAT = 8;
    localparam logic ZDBZ = 1'b0;
`endif

    seq_divider dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one operation, wait for the result, check it, then drain it.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er,
                          input logic edbz, input int elat);
        int n;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(elat));
        chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
        chk({tag, "_remainder"}, 32'(remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [11:0] q[$];
        logic [11:0] item;
        logic [7:0]  a, exp_q;
        logic [3:0]  b, exp_r;
        logic        exp_d, acc, drn, seen;
        int          sent, got, cyc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 8'd0;
        divisor   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("d200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);
        run_op("d255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8);
        run_op("d5_9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 8);
        run_op("zero_div", 8'hA6, 4'd0, 8'hFF, 4'h6, ZDBZ, ZLAT);

        // Backpressure: result held, second request ignored until drained.
        dividend = 8'd100;
        divisor  = 4'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_latency", 32'(cyc), 32'd8);
        dividend = 8'd50;
        divisor  = 4'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_quotient", 32'(quotient), 32'd33);
            chk("bp_hold_remainder", 32'(remainder), 32'd1);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp_idle_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_valid", 32'(out_valid), 32'd0);
        chk("bp_idle_quotient", 32'(quotient), 32'd33);
        chk("bp_idle_remainder", 32'(remainder), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("bp_no_ghost_result", 32'(seen), 32'd0);

        // Reset pulse in the middle of an operation.
        dividend = 8'd200;
        divisor  = 4'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        chk("midrst_dbz", 32'(div_by_zero), 32'd0);
        #1;
        rst = 1'b0;
        run_op("d9_2", 8'd9, 4'd2, 8'd4, 4'd1, 1'b0, 8);

        // Random sweep with in_valid held high and the consumer always ready.
        out_ready = 1'b1;
        dividend  = 8'($urandom_range(0, 255));
        divisor   = 4'($urandom_range(0, 15));
        in_valid  = 1'b1;
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 20 && cyc < 2000) begin
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            if (drn) begin
                if (q.size() > 0) begin
                    item = q.pop_front();
                    a = item[11:4];
                    b = item[3:0];
                    if (b == 4'd0) begin
                        exp_q = 8'hFF;
                        exp_r = a[3:0];
                        exp_d = ZDBZ;
                    end else begin
                        exp_q = a / {4'd0, b};
                        exp_r = 4'(a % {4'd0, b});
                        exp_d = 1'b0;
                    end
                    chk("sweep_quotient", 32'(quotient), 32'(exp_q));
                    chk("sweep_remainder", 32'(remainder), 32'(exp_r));
                    chk("sweep_dbz", 32'(div_by_zero), 32'(exp_d));
                end else begin
                    chk("sweep_unexpected_result", 32'(q.size()), 32'd1);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                q.push_back({dividend, divisor});
                sent++;
                if (sent < 20) begin
                    dividend = 8'($urandom_range(0, 255));
                    divisor  = 4'($urandom_range(0, 15));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("sweep_results", 32'(got), 32'd20);
        chk("sweep_sent", 32'(sent), 32'd20);
        chk("sweep_leftover", 32'(q.size()), 32'd0);
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
